matmul_compute: RTL and testbench

Downstream consumer of the input memory stage. Once A (M x K) and B (K x N) are loaded, it reads both memories, computes C = A*B one element at a time with a single multiply-accumulate (MAC) unit, and streams C row-major out on an AXI-Stream master. After the last element is accepted, it pulses compute_finished so the input stage can accept the next matrix pair.

---
 rtl/matmul_pkg.sv | 7 +
 rtl/matmul_compute_mac.sv | 25 ++
 rtl/matmul_compute.sv | 105 ++++++++++
 tb/tb_matmul_compute.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: FSM state type and minimum accumulator width helper for matmul_compute
package matmul_pkg;
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, OUT, DONE, WAIT_CLR} state_t;
  function automatic int min_outw(input int inw, input int maxk);
    return 2 * inw + $clog2(maxk);
  endfunction
endpackage

// File: rtl/matmul_compute_mac.sv
// mac_unit: signed multiply with sign-extended wrapping accumulate register
module mac_unit #(
  parameter int INW  = 12,
  parameter int OUTW = 28
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [INW-1:0]  a,
  input  logic signed [INW-1:0]  b,
  output logic signed [OUTW-1:0] acc
);
  logic signed [2*INW-1:0] prod;
  logic signed [OUTW-1:0] acc_d, acc_q;
  always_comb begin
    prod  = a * b;
    acc_d = clr ? '0 : en ? acc_q + OUTW'(prod) : acc_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else acc_q <= acc_d;
  end
  assign acc = acc_q;
endmodule

// File: rtl/matmul_compute.sv
// matmul_compute: single-MAC C=A*B streamed row-major over AXI-Stream; MATMUL_RELU_EN clamps negative outputs to 0
module matmul_compute
  import matmul_pkg::*;
#(
  parameter int INW         = 12,
  parameter int OUTW        = 28,
  parameter int M           = 7,
  parameter int N           = 9,
  parameter int MAXK        = 8,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          matrices_loaded,
  input  logic [K_BITS-1:0]             K,
  output logic [A_ADDR_BITS-1:0]        A_read_addr,
  input  logic signed [INW-1:0]         A_data,
  output logic [B_ADDR_BITS-1:0]        B_read_addr,
  input  logic signed [INW-1:0]         B_data,
  output logic                          compute_finished,
  output logic signed [OUTW-1:0]        AXIS_TDATA,
  output logic                          AXIS_TVALID,
  input  logic                          AXIS_TREADY
);
  localparam int MB = M > 1 ? $clog2(M) : 1;
  localparam int NB = N > 1 ? $clog2(N) : 1;
  if (OUTW < min_outw(INW, MAXK)) begin : g_outw_check
    $error("OUTW too small for INW and MAXK");
  end
  state_t state_q, state_d;
  logic [MB-1:0] m_q, m_d;
  logic [NB-1:0] n_q, n_d;
  logic [K_BITS-1:0] k_q, k_d, kq_q, kq_d;
  logic tvalid_q, tvalid_d, done_q, done_d, last_n, last_m, clr, en;
  logic signed [OUTW-1:0] acc;
  mac_unit #(.INW(INW), .OUTW(OUTW)) u_mac (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .a(A_data), .b(B_data), .acc(acc)
  );
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    kq_d    = kq_q;
    last_n  = n_q == NB'(N - 1);
    last_m  = m_q == MB'(M - 1);
    case (state_q)
      IDLE: if (matrices_loaded) begin
        kq_d    = K;
        m_d     = '0;
        n_d     = '0;
        k_d     = '0;
        state_d = K == '0 ? OUT : MAC;
      end
      MAC: begin
        k_d     = k_q + 1'b1;
        state_d = k_q == kq_q - 1'b1 ? DRAIN : MAC;
      end
      DRAIN: state_d = OUT;
      OUT: if (AXIS_TREADY) begin
        k_d     = '0;
        n_d     = last_n ? '0 : n_q + 1'b1;
        m_d     = last_n ? m_q + 1'b1 : m_q;
        state_d = last_n && last_m ? DONE : kq_q == '0 ? OUT : MAC;
      end
      DONE: state_d = WAIT_CLR;
      WAIT_CLR: state_d = matrices_loaded ? WAIT_CLR : IDLE;
      default: state_d = IDLE;
    endcase
    tvalid_d = state_d == OUT;
    done_d   = state_d == DONE;
    clr      = state_q == IDLE || (state_q == OUT && AXIS_TREADY);
    en       = (state_q == MAC && k_q != '0) || state_q == DRAIN;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      kq_q     <= '0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      kq_q     <= kq_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
    end
  end
  assign A_read_addr = state_q == MAC ? A_ADDR_BITS'(m_q) * A_ADDR_BITS'(kq_q) + A_ADDR_BITS'(k_q) : '0;
  assign B_read_addr = state_q == MAC ? B_ADDR_BITS'(k_q) * B_ADDR_BITS'(N) + B_ADDR_BITS'(n_q) : '0;
  assign AXIS_TVALID = tvalid_q;
  assign compute_finished = done_q;
`ifdef MATMUL_RELU_EN
  assign AXIS_TDATA = acc[OUTW-1] ? '0 : acc;
`else
  assign AXIS_TDATA = acc;
`endif
endmodule

// File: tb/tb_matmul_compute.sv
// tb_matmul_compute: scoreboard bench for matmul_compute with M=N=2, stalls, K=0, extremes and mid-run reset
module tb_matmul_compute;
  localparam int INW = 12, OUTW = 28, M = 2, N = 2, MAXK = 8;
  localparam int KB = $clog2(MAXK + 1), AB = $clog2(M * MAXK), BB = $clog2(MAXK * N);
  logic clk = 0, reset = 0, matrices_loaded = 0, AXIS_TREADY = 0;
  logic [KB-1:0] K = '0;
  logic [AB-1:0] A_read_addr;
  logic [BB-1:0] B_read_addr;
  logic signed [INW-1:0] A_data = '0, B_data = '0;
  logic compute_finished, AXIS_TVALID;
  logic signed [OUTW-1:0] AXIS_TDATA;
  logic signed [INW-1:0] a_mem [M*MAXK];
  logic signed [INW-1:0] b_mem [MAXK*N];
  logic signed [OUTW-1:0] exp_q [$];
  logic signed [OUTW-1:0] hold_d;
  logic hold_v = 0, rdy_force = 0;
  int errs = 0, checks = 0, cyc = 0, beats = 0, fins = 0, first_cyc = -1, rmode = 0, stall = 0;
  matmul_compute #(.INW(INW), .OUTW(OUTW), .M(M), .N(N), .MAXK(MAXK)) dut (
    .clk(clk), .reset(reset), .matrices_loaded(matrices_loaded), .K(K),
    .A_read_addr(A_read_addr), .A_data(A_data), .B_read_addr(B_read_addr), .B_data(B_data),
    .compute_finished(compute_finished), .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID),
    .AXIS_TREADY(AXIS_TREADY)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    A_data <= a_mem[A_read_addr];
    B_data <= b_mem[B_read_addr];
    cyc <= cyc + 1;
  end
  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (rmode == 1) begin
      if (stall > 0) begin
        stall--;
        AXIS_TREADY = 0;
      end else begin
        AXIS_TREADY = 1;
        stall = $urandom_range(0, 3);
      end
    end else AXIS_TREADY = rmode == 0 ? 1'b1 : rdy_force;
  end
  always @(negedge clk) begin
    if (!reset) hold_v = 0;
    else begin
      if (AXIS_TVALID && first_cyc < 0) first_cyc = cyc;
      if (hold_v) begin
        chk("stall_valid", AXIS_TVALID, 1);
        chk("stall_data", AXIS_TDATA, hold_d);
      end
      hold_v = AXIS_TVALID && !AXIS_TREADY;
      hold_d = AXIS_TDATA;
      if (AXIS_TVALID && AXIS_TREADY) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else chk("beat", AXIS_TDATA, exp_q.pop_front());
        beats++;
      end
      if (compute_finished) fins++;
    end
  end
  task automatic load(input int kv, input int pat);
    longint s;
    logic signed [OUTW-1:0] e;
    for (int i = 0; i < M * MAXK; i++) a_mem[i] = pat == 0 ? INW'(i + 1) : -12'sd2048;
    for (int i = 0; i < MAXK * N; i++) b_mem[i] = pat == 0 ? INW'(i + 5) : pat == 1 ? -12'sd2048 : 12'sd2047;
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) begin
        s = 0;
        for (int k = 0; k < kv; k++) s += longint'(a_mem[m*kv+k]) * longint'(b_mem[k*N+n]);
        e = s[OUTW-1:0];
`ifdef MATMUL_RELU_EN
        if (e < 0) e = '0;
`endif
        exp_q.push_back(e);
      end
    K = KB'(kv);
  endtask
  task automatic run(input int kv, input int pat);
    int c0;
    load(kv, pat);
    fins = 0;
    beats = 0;
    first_cyc = -1;
    @(posedge clk);
    #1;
    c0 = cyc;
    matrices_loaded = 1;
    for (int i = 0; i < 500 && fins == 0; i++) @(posedge clk);
    chk("finished", fins, 1);
    repeat (4) begin
      @(negedge clk);
      chk("wait_clr_quiet", AXIS_TVALID, 0);
    end
    chk("beats", beats, M * N);
    chk("fins_once", fins, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("latency", first_cyc - c0, kv == 0 ? 1 : kv + 2);
    exp_q.delete();
    matrices_loaded = 0;
    repeat (2) @(posedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", AXIS_TVALID, 0);
    chk("rst_tdata", AXIS_TDATA, 0);
    chk("rst_fin", compute_finished, 0);
    chk("rst_aaddr", A_read_addr, 0);
    chk("rst_baddr", B_read_addr, 0);
    reset = 1;
    run(2, 0);
    rmode = 1;
    run(2, 0);
    run(8, 1);
    run(8, 2);
    rmode = 0;
    run(0, 0);
    rmode = 2;
    rdy_force = 1;
    load(2, 0);
    beats = 0;
    @(posedge clk);
    #1;
    matrices_loaded = 1;
    for (int i = 0; i < 50 && beats < 1; i++) @(negedge clk);
    @(posedge clk);
    #1;
    rdy_force = 0;
    for (int i = 0; i < 20 && !AXIS_TVALID; i++) @(negedge clk);
    chk("beat2_seen", AXIS_TVALID, 1);
    #2;
    reset = 0;
    #1;
    chk("async_rst_tvalid", AXIS_TVALID, 0);
    chk("async_rst_fin", compute_finished, 0);
    chk("async_rst_tdata", AXIS_TDATA, 0);
    matrices_loaded = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    rmode = 0;
    run(2, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
